fft_frame_sequencer: RTL

- Sequences the 8-point parallel CORDIC FFT core (`fft`) from a serial complex-sample stream.
- Collects N samples into an input buffer, drives the core's parallel x/y inputs, and holds `en` for a fixed core latency.
- Captures the parallel xout/yout results, then streams N results out over a valid/ready interface.
- Sits between the sample source and the `fft` instance; owns the core's `en`. The core's `reset` is tied to the same `reset`.

---
 rtl/fft_seq_pkg.sv | 25 ++
 rtl/fft_seq_latency_timer.sv | 26 ++
 rtl/fft_frame_sequencer.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/fft_seq_pkg.sv
// Shared types and helpers for the FFT frame sequencer.
package fft_seq_pkg;

  localparam int DEF_N           = 8;
  localparam int DEF_W           = 32;
  localparam int DEF_FFT_LATENCY = 20;

  typedef enum logic [1:0] {LOAD, RUN, UNLOAD} seq_state_t;

  typedef struct packed {
    logic signed [DEF_W-1:0] re;
    logic signed [DEF_W-1:0] im;
  } cplx_t;

  // Reverses the low 'bits' bits of v; anything above them is dropped.
  function automatic logic [31:0] bitrev(input logic [31:0] v, input int bits);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) begin
      if (i < bits) r[bits-1-i] = v[i];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_seq_latency_timer.sv
// Loadable down-counter that times how long the FFT core stays enabled.
module fft_seq_latency_timer
  import fft_seq_pkg::*;
#(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             count,
  output logic             zero
);

  logic [WIDTH-1:0] value;

  // Saturates at zero so a lingering count cannot wrap back to the top.
  always_ff @(posedge clk) begin
    if (reset)                value <= '0;
    else if (load)            value <= load_value;
    else if (count && !zero)  value <= value - WIDTH'(1);
  end

  assign zero = (value == '0);

endmodule

// File: rtl/fft_frame_sequencer.sv
// Serial-to-parallel frame sequencer around the 8-point CORDIC FFT core.
// Define FFT_FRAME_SEQUENCER_BITREV_EN to emit results in bit-reversed lane order.
module fft_frame_sequencer
  import fft_seq_pkg::*;
#(
  parameter int N           = DEF_N,
  parameter int W           = DEF_W,
  parameter int FFT_LATENCY = DEF_FFT_LATENCY
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic signed [W-1:0] s_re,
  input  logic signed [W-1:0] s_im,
  output logic                fft_en,
  output logic [N*W-1:0]      fft_x,
  output logic [N*W-1:0]      fft_y,
  input  logic [N*W-1:0]      fft_xout,
  input  logic [N*W-1:0]      fft_yout,
  output logic                m_valid,
  input  logic                m_ready,
  output logic signed [W-1:0] m_re,
  output logic signed [W-1:0] m_im,
  output logic                m_last,
  output logic                busy
);

  localparam int IW = $clog2(N);
  localparam int TW = $clog2(FFT_LATENCY + 1);
  localparam logic [IW-1:0] LAST       = IW'(N - 1);
  localparam logic [TW-1:0] TIMER_INIT = TW'(FFT_LATENCY - 1);

  seq_state_t state, state_next;

  logic [IW-1:0]         idx, oidx, oidx_inc;
  logic [N-1:0][W-1:0]   ibuf_re, ibuf_im;
  logic [N-1:0][W-1:0]   obuf_re, obuf_im;
  logic [N-1:0][W-1:0]   xout_lanes, yout_lanes;
  logic                  in_fire, frame_in_done, out_fire, timer_zero;

  function automatic logic [IW-1:0] lane_order(input logic [IW-1:0] i);
    logic [31:0] r;
`ifdef FFT_FRAME_SEQUENCER_BITREV_EN
    r = bitrev(32'(i), IW);
`else
    r = 32'(i);
`endif
    return r[IW-1:0];
  endfunction

  assign in_fire       = s_valid && s_ready && (state == LOAD);
  assign frame_in_done = in_fire && (idx == LAST);
  assign out_fire      = m_valid && m_ready;
  assign oidx_inc      = oidx + IW'(1);
  assign xout_lanes    = fft_xout;
  assign yout_lanes    = fft_yout;
  assign fft_x         = ibuf_re;
  assign fft_y         = ibuf_im;
  assign busy          = (state != LOAD);

  fft_seq_latency_timer #(.WIDTH(TW)) u_timer (
    .clk        (clk),
    .reset      (reset),
    .load       (frame_in_done),
    .load_value (TIMER_INIT),
    .count      (state == RUN),
    .zero       (timer_zero)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= LOAD;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      LOAD:    if (frame_in_done)       state_next = RUN;
      RUN:     if (timer_zero)          state_next = UNLOAD;
      UNLOAD:  if (out_fire && m_last)  state_next = LOAD;
      default:                          state_next = LOAD;
    endcase
  end

  // s_ready is registered from the current state, which leaves one idle
  // LOAD cycle after each frame before the next sample can be taken.
  always_ff @(posedge clk) begin
    if (reset) begin
      idx     <= '0;
      oidx    <= '0;
      s_ready <= 1'b0;
      fft_en  <= 1'b0;
      m_valid <= 1'b0;
      m_last  <= 1'b0;
      m_re    <= '0;
      m_im    <= '0;
      ibuf_re <= '0;
      ibuf_im <= '0;
      obuf_re <= '0;
      obuf_im <= '0;
    end else begin
      s_ready <= (state == LOAD) && !frame_in_done;
      case (state)
        LOAD: begin
          if (in_fire) begin
            ibuf_re[idx] <= s_re;
            ibuf_im[idx] <= s_im;
            idx          <= (idx == LAST) ? '0 : idx + IW'(1);
            if (idx == LAST) fft_en <= 1'b1;
          end
        end
        RUN: begin
          // The first result bypasses obuf so m_valid can rise right after capture.
          if (timer_zero) begin
            fft_en  <= 1'b0;
            obuf_re <= xout_lanes;
            obuf_im <= yout_lanes;
            oidx    <= '0;
            m_valid <= 1'b1;
            m_last  <= 1'b0;
            m_re    <= xout_lanes[lane_order('0)];
            m_im    <= yout_lanes[lane_order('0)];
          end
        end
        UNLOAD: begin
          if (out_fire) begin
            if (m_last) begin
              m_valid <= 1'b0;
              m_last  <= 1'b0;
              oidx    <= '0;
            end else begin
              oidx    <= oidx_inc;
              m_re    <= obuf_re[lane_order(oidx_inc)];
              m_im    <= obuf_im[lane_order(oidx_inc)];
              m_last  <= (oidx_inc == LAST);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
